// File: rtl/exmem_stage.sv
// rtl/exmem_stage.sv - EX/MEM pipeline register that owns the data-cache request handshake
// Optional feature macro: EXMEM_PERF_EN (adds the mem_stall_cnt output)
module exmem_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              exW,
  input  logic              exRST,
  input  logic              excuDRE,
  input  logic              excuDWE,
  input  logic              excuHALT,
  input  logic              exMemToReg,
  input  logic              exWEN,
  input  logic              exJALflag,
  input  logic [REG_W-1:0]  exwsel,
  input  logic [WORD_W-1:0] exaluout,
  input  logic [WORD_W-1:0] exstore,
  input  logic [WORD_W-1:0] exnpc,
  output logic              memcuDRE,
  output logic              memcuDWE,
  output logic              memHALT,
  output logic              memMemToReg,
  output logic              memWEN,
  output logic              memJALflag,
  output logic [REG_W-1:0]  memwsel,
  output logic [WORD_W-1:0] memaluout,
  output logic [WORD_W-1:0] memstore,
  output logic [WORD_W-1:0] memnpc,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic [WORD_W-1:0] memload,
  output logic              mem_busy
`ifdef EXMEM_PERF_EN
  ,
  output logic [31:0]       mem_stall_cnt
`endif
);

  typedef struct packed {
    logic              dre;
    logic              dwe;
    logic              halt;
    logic              mem2reg;
    logic              wen;
    logic              jal;
    logic [REG_W-1:0]  wsel;
    logic [WORD_W-1:0] aluout;
    logic [WORD_W-1:0] store;
    logic [WORD_W-1:0] npc;
  } exmem_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  exmem_t            r_mem;
  exmem_t            w_ex;
  state_t            r_state;
  state_t            w_next;
  logic [WORD_W-1:0] r_cap;
  logic              w_req_active;
  logic              w_load;
  logic              w_load_mem;

  assign w_ex = '{dre: excuDRE, dwe: excuDWE, halt: excuHALT, mem2reg: exMemToReg,
                  wen: exWEN, jal: exJALflag, wsel: exwsel, aluout: exaluout,
                  store: exstore, npc: exnpc};

  // A halted stage never talks to the cache, even if the FSM was left in REQ.
  assign w_req_active = (r_state == REQ) && !r_mem.halt;
  assign mem_busy     = w_req_active && !dhit;
  assign w_load       = exW && !mem_busy && !r_mem.halt;
  assign w_load_mem   = !exRST && (excuDRE || excuDWE);

  always_comb begin
    w_next = r_state;
    if (r_mem.halt) begin
      w_next = r_state;
    end else if (w_load) begin
      w_next = w_load_mem ? REQ : IDLE;
    end else if ((r_state == REQ) && dhit) begin
      w_next = DONE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_mem <= '0;
    end else if (w_load) begin
      r_mem <= exRST ? '0 : w_ex;
    end
  end

  // Capture is independent of w_load so a same-edge advance still keeps the data.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cap <= '0;
    end else if (w_req_active && dhit && r_mem.dre) begin
      r_cap <= dmemload;
    end
  end

  // Load wins when both enables are set; the write request is suppressed.
  assign dmemREN   = w_req_active && r_mem.dre;
  assign dmemWEN   = w_req_active && r_mem.dwe && !r_mem.dre;
  assign dmemaddr  = r_mem.aluout;
  assign dmemstore = r_mem.store;
  assign memload   = (w_req_active && dhit) ? dmemload : r_cap;

  assign memcuDRE    = r_mem.dre;
  assign memcuDWE    = r_mem.dwe;
  assign memHALT     = r_mem.halt;
  assign memMemToReg = r_mem.mem2reg;
  assign memWEN      = r_mem.wen;
  assign memJALflag  = r_mem.jal;
  assign memwsel     = r_mem.wsel;
  assign memaluout   = r_mem.aluout;
  assign memstore    = r_mem.store;
  assign memnpc      = r_mem.npc;

`ifdef EXMEM_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
    end else if (mem_busy && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign mem_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_exmem_stage.sv
// tb/tb_exmem_stage.sv - table-driven and randomized bench for exmem_stage
// Honours EXMEM_PERF_EN when defined.
module tb_exmem_stage;

  logic        CLK, nRST;
  logic        exW, exRST, excuDRE, excuDWE, excuHALT, exMemToReg, exWEN, exJALflag;
  logic [4:0]  exwsel;
  logic [31:0] exaluout, exstore, exnpc;
  logic        memcuDRE, memcuDWE, memHALT, memMemToReg, memWEN, memJALflag;
  logic [4:0]  memwsel;
  logic [31:0] memaluout, memstore, memnpc;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit;
  logic [31:0] dmemload, memload;
  logic        mem_busy;
`ifdef EXMEM_PERF_EN
  logic [31:0] mem_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  exmem_stage #(.WORD_W(32), .REG_W(5)) dut (
    .CLK(CLK), .nRST(nRST),
    .exW(exW), .exRST(exRST), .excuDRE(excuDRE), .excuDWE(excuDWE), .excuHALT(excuHALT),
    .exMemToReg(exMemToReg), .exWEN(exWEN), .exJALflag(exJALflag), .exwsel(exwsel),
    .exaluout(exaluout), .exstore(exstore), .exnpc(exnpc),
    .memcuDRE(memcuDRE), .memcuDWE(memcuDWE), .memHALT(memHALT), .memMemToReg(memMemToReg),
    .memWEN(memWEN), .memJALflag(memJALflag), .memwsel(memwsel), .memaluout(memaluout),
    .memstore(memstore), .memnpc(memnpc),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .memload(memload), .mem_busy(mem_busy)
`ifdef EXMEM_PERF_EN
    , .mem_stall_cnt(mem_stall_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    assert (!(nRST && exW && excuDRE && excuDWE)) else $error("illegal op: DRE and DWE both set");
  end

  // Reference model: the latched op, whether its cache transaction is still open, last load data.
  logic        m_dre, m_dwe, m_halt, m_m2r, m_wen, m_jal, m_pending;
  logic [4:0]  m_wsel;
  logic [31:0] m_alu, m_store, m_npc, m_cap, m_cnt;

  task automatic model_reset();
    {m_dre, m_dwe, m_halt, m_m2r, m_wen, m_jal, m_pending} = '0;
    m_wsel = '0;
    {m_alu, m_store, m_npc, m_cap, m_cnt} = '0;
  endtask

  task automatic model_edge();
    logic open_now, busy, ld;
    open_now = m_pending && !m_halt;
    busy     = open_now && !dhit;
    ld       = exW && !busy && !m_halt;
    if (busy && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (open_now && dhit) begin
      if (m_dre) m_cap = dmemload;
      m_pending = 1'b0;
    end
    if (ld) begin
      if (exRST) begin
        {m_dre, m_dwe, m_halt, m_m2r, m_wen, m_jal, m_pending} = '0;
        m_wsel = '0;
        {m_alu, m_store, m_npc} = '0;
      end else begin
        {m_dre, m_dwe, m_halt, m_m2r, m_wen, m_jal} =
          {excuDRE, excuDWE, excuHALT, exMemToReg, exWEN, exJALflag};
        m_wsel = exwsel;
        {m_alu, m_store, m_npc} = {exaluout, exstore, exnpc};
        m_pending = excuDRE || excuDWE;
      end
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample_and_check();
    logic open_now;
    #3;
    open_now = m_pending && !m_halt;
    chk("mem_regs",
        {memcuDRE, memcuDWE, memHALT, memMemToReg, memWEN, memJALflag, memwsel, memaluout, memstore, memnpc},
        {m_dre, m_dwe, m_halt, m_m2r, m_wen, m_jal, m_wsel, m_alu, m_store, m_npc});
    chk("dmem_req", {dmemREN, dmemWEN}, {open_now && m_dre, open_now && m_dwe && !m_dre});
    chk("mem_busy", mem_busy, open_now && !dhit);
    chk("memload", memload, (open_now && dhit) ? dmemload : m_cap);
    chk("dmem_addr_store", {dmemaddr, dmemstore}, {m_alu, m_store});
`ifdef EXMEM_PERF_EN
    chk("stall_cnt", mem_stall_cnt, m_cnt);
`endif
  endtask

  task automatic advance();
    model_edge();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    {exW, exRST, excuDRE, excuDWE, excuHALT, exMemToReg, exWEN, exJALflag, dhit} = '0;
    exwsel = '0;
    {exaluout, exstore, exnpc, dmemload} = '0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  typedef struct packed {
    logic [4:0]  ctl;    // exW, exRST, DRE, DWE, HALT
    logic [31:0] alu;
    logic [31:0] store;
    logic        hit;
    logic [31:0] dload;
    logic [3:0]  e;      // ren, wen, busy, halt
    logic [31:0] e_alu;
    logic [31:0] e_load;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] ctl, input logic [31:0] alu, input logic [31:0] store,
                              input logic hit, input logic [31:0] dload, input logic [3:0] e,
                              input logic [31:0] e_alu, input logic [31:0] e_load);
    vec_t v;
    v.ctl = ctl; v.alu = alu; v.store = store; v.hit = hit; v.dload = dload;
    v.e = e; v.e_alu = e_alu; v.e_load = e_load;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    {exW, exRST, excuDRE, excuDWE, excuHALT} = v.ctl;
    exMemToReg = v.ctl[2];
    exWEN      = !v.ctl[1];
    exJALflag  = 1'b0;
    exaluout   = v.alu;
    exwsel     = v.alu[4:0];
    exnpc      = v.alu + 32'd4;
    exstore    = v.store;
    dhit       = v.hit;
    dmemload   = v.dload;
  endtask

  vec_t vt[16];

  initial begin
    vt[0]  = mk(5'b10100, 32'h40, 32'h0,    1'b0, 32'h0,        4'b0000, 32'h0,  32'h0);
    vt[1]  = mk(5'b10000, 32'h55, 32'h0,    1'b0, 32'h0,        4'b1010, 32'h40, 32'h0);
    vt[2]  = mk(5'b10000, 32'h55, 32'h0,    1'b0, 32'h0,        4'b1010, 32'h40, 32'h0);
    vt[3]  = mk(5'b10000, 32'h55, 32'h0,    1'b1, 32'hDEADBEEF, 4'b1000, 32'h40, 32'hDEADBEEF);
    vt[4]  = mk(5'b10100, 32'h60, 32'h0,    1'b0, 32'h0,        4'b0000, 32'h55, 32'hDEADBEEF);
    vt[5]  = mk(5'b00000, 32'h0,  32'h0,    1'b1, 32'hCAFEF00D, 4'b1000, 32'h60, 32'hCAFEF00D);
    vt[6]  = mk(5'b00000, 32'h0,  32'h0,    1'b0, 32'h0,        4'b0000, 32'h60, 32'hCAFEF00D);
    vt[7]  = mk(5'b00000, 32'h0,  32'h0,    1'b1, 32'h11111111, 4'b0000, 32'h60, 32'hCAFEF00D);
    vt[8]  = mk(5'b10010, 32'h80, 32'h1234, 1'b0, 32'h0,        4'b0000, 32'h60, 32'hCAFEF00D);
    vt[9]  = mk(5'b10000, 32'h90, 32'h0,    1'b1, 32'h22222222, 4'b0100, 32'h80, 32'h22222222);
    vt[10] = mk(5'b00000, 32'h0,  32'h0,    1'b0, 32'h0,        4'b0000, 32'h90, 32'hCAFEF00D);
    vt[11] = mk(5'b11010, 32'hA0, 32'h5,    1'b0, 32'h0,        4'b0000, 32'h90, 32'hCAFEF00D);
    vt[12] = mk(5'b00000, 32'h0,  32'h0,    1'b0, 32'h0,        4'b0000, 32'h0,  32'hCAFEF00D);
    vt[13] = mk(5'b10001, 32'hB0, 32'h0,    1'b0, 32'h0,        4'b0000, 32'h0,  32'hCAFEF00D);
    vt[14] = mk(5'b10100, 32'hC0, 32'h0,    1'b0, 32'h0,        4'b0001, 32'hB0, 32'hCAFEF00D);
    vt[15] = mk(5'b10100, 32'hC0, 32'h0,    1'b1, 32'h33333333, 4'b0001, 32'hB0, 32'hCAFEF00D);

    nRST = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge CLK);
    sample_and_check();
    chk("reset_state",
        {memcuDRE, memcuDWE, memHALT, memMemToReg, memWEN, memJALflag, memwsel, memaluout,
         memstore, memnpc, dmemREN, dmemWEN, mem_busy, memload}, '0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 16; i++) begin
      apply(vt[i]);
      sample_and_check();
      chk($sformatf("vec%0d_req_busy_halt", i), {dmemREN, dmemWEN, mem_busy, memHALT}, vt[i].e);
      chk($sformatf("vec%0d_memaluout", i), memaluout, vt[i].e_alu);
      chk($sformatf("vec%0d_memload", i), memload, vt[i].e_load);
      advance();
    end

    // Reset in the middle of an outstanding load.
    do_reset();
    exW = 1'b1; excuDRE = 1'b1; exMemToReg = 1'b1; exaluout = 32'h40;
    sample_and_check();
    advance();
    clear_inputs();
    sample_and_check();
    advance();
    sample_and_check();
    advance();
    sample_and_check();
    chk("req_before_rst", {dmemREN, mem_busy}, 2'b11);
`ifdef EXMEM_PERF_EN
    chk("stall_cnt_two", mem_stall_cnt, 32'd2);
`endif
    nRST = 1'b0;
    #1;
    chk("ren_async_rst", dmemREN, 1'b0);
    chk("outs_async_rst", {memcuDRE, memHALT, memaluout, memnpc, mem_busy, memload}, '0);
`ifdef EXMEM_PERF_EN
    chk("stall_cnt_rst", mem_stall_cnt, 32'd0);
`endif
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;

    for (int ep = 0; ep < 5; ep++) begin
      for (int c = 0; c < 120; c++) begin
        int sel;
        sel        = int'($urandom_range(0, 2));
        exW        = ($urandom_range(0, 9) < 7);
        exRST      = ($urandom_range(0, 9) == 0);
        excuDRE    = (sel == 1);
        excuDWE    = (sel == 2);
        excuHALT   = (sel == 0) && ($urandom_range(0, 79) == 0);
        exMemToReg = 1'($urandom);
        exWEN      = 1'($urandom);
        exJALflag  = 1'($urandom);
        exwsel     = 5'($urandom);
        exaluout   = $urandom;
        exstore    = $urandom;
        exnpc      = $urandom;
        dhit       = ($urandom_range(0, 9) < 4);
        dmemload   = $urandom;
        sample_and_check();
        advance();
      end
      do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
